// File: rtl/gshare_bht.sv
// rtl/gshare_bht.sv - gshare branch predictor with SRAM-friendly init walk
//
// Purpose:
//   Predicts branch direction for every slot of a fetch block using a pattern
//   history table (PHT) of 2-bit saturating counters indexed by PC XOR global
//   history. Keeps a speculative global history register (GHR) that is
//   repaired from the branch's own snapshot on a mispredict. After reset or
//   flush the PHT is rewritten one entry per cycle, so the table needs only a
//   single write port and can map onto an SRAM macro.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         clear GHR and restart the init walk
//   debug_mode_i    freeze PHT and GHR (predictions still served)
//   vpc_i           fetch PC
//   pred_valid_o    per-slot prediction valid
//   pred_taken_o    per-slot prediction taken
//   ghr_o           current GHR, carried by the frontend with each branch
//   spec_valid_i    push spec_taken_i into the GHR
//   spec_taken_i    speculative outcome
//   upd_valid_i     resolved-branch update strobe
//   upd_pc_i        resolved branch PC
//   upd_ghr_i       GHR snapshot taken when the branch was predicted
//   upd_taken_i     resolved outcome
//   upd_mispred_i   resolved branch was mispredicted
//   init_busy_o     init walk in progress
module gshare_bht #(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned HIST_LEN        = 10,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned OFFSET          = 1,
  parameter int unsigned VLEN            = 39,
  parameter logic [1:0]  CTR_INIT        = 2'b01
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [HIST_LEN-1:0]        ghr_o,
  input  logic                       spec_valid_i,
  input  logic                       spec_taken_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic [HIST_LEN-1:0]        upd_ghr_i,
  input  logic                       upd_taken_i,
  input  logic                       upd_mispred_i,
  output logic                       init_busy_o
);

  localparam int unsigned IDX_BITS = $clog2(NR_ENTRIES);
  localparam int unsigned IPF_BITS = $clog2(INSTR_PER_FETCH);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NR_ENTRIES - 1);
  // Bits below the fetch-block boundary; replaced by the slot number per slot.
  localparam logic [VLEN-1:0] LOW_MASK = (VLEN'(1) << (OFFSET + IPF_BITS)) - VLEN'(1);

  typedef enum logic {
    S_INIT,
    S_IDLE
  } state_e;

  // PC XOR zero-extended history; the full PC is shifted rather than sliced
  // so that the unused upper address bits need no special handling.
  function automatic logic [IDX_BITS-1:0] pht_idx(input logic [VLEN-1:0] pc,
                                                  input logic [HIST_LEN-1:0] h);
    return IDX_BITS'(pc >> OFFSET) ^ IDX_BITS'(h);
  endfunction

  // Shift a new outcome into the history; for HIST_LEN == 1 this degenerates
  // to replacing the single bit.
  function automatic logic [HIST_LEN-1:0] shift_in(input logic [HIST_LEN-1:0] h,
                                                   input logic b);
    return HIST_LEN'({h, b});
  endfunction

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   widx_q, widx_d;
  logic [HIST_LEN-1:0]   ghr_q, ghr_d;

  logic                  pht_valid [NR_ENTRIES];
  logic [1:0]            pht_ctr   [NR_ENTRIES];

  logic                  wr_en;
  logic [IDX_BITS-1:0]   wr_idx;
  logic                  wr_valid;
  logic [1:0]            wr_ctr;

  logic [IDX_BITS-1:0]   upd_idx;
  logic [1:0]            upd_ctr_old;
  logic [1:0]            upd_ctr_new;

  logic [IDX_BITS-1:0]   slot_idx [INSTR_PER_FETCH];

  assign init_busy_o = (state_q == S_INIT);
  assign ghr_o       = ghr_q;

  // Read side: one PHT lookup per slot, combinational on vpc_i and the GHR.
  always_comb begin
    slot_idx = '{default: '0};
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      slot_idx[i] = pht_idx((vpc_i & ~LOW_MASK) | (VLEN'(unsigned'(i)) << OFFSET), ghr_q);
    end
  end

  always_comb begin
    pred_valid_o = '0;
    pred_taken_o = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      pred_valid_o[i] = pht_valid[slot_idx[i]] & ~init_busy_o;
      pred_taken_o[i] = pht_ctr[slot_idx[i]][1];
    end
  end

  // Resolved-branch counter update, saturating at both ends.
  always_comb begin
    upd_idx     = pht_idx(upd_pc_i, upd_ghr_i);
    upd_ctr_old = pht_ctr[upd_idx];
    upd_ctr_new = upd_ctr_old;
    if (upd_taken_i) begin
      if (upd_ctr_old != 2'b11) upd_ctr_new = upd_ctr_old + 2'd1;
    end else begin
      if (upd_ctr_old != 2'b00) upd_ctr_new = upd_ctr_old - 2'd1;
    end
  end

  // Next-state logic. The single PHT write port is shared between the init
  // walk and resolved-branch updates; the two never coincide because updates
  // are ignored while the walk runs.
  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    ghr_d    = ghr_q;
    wr_en    = 1'b0;
    wr_idx   = widx_q;
    wr_valid = 1'b0;
    wr_ctr   = CTR_INIT;

    if (flush_i) begin
      state_d = S_INIT;
      widx_d  = '0;
      ghr_d   = '0;
    end else begin
      case (state_q)
        S_INIT: begin
          wr_en  = 1'b1;
          widx_d = widx_q + IDX_BITS'(1);
          ghr_d  = '0;
          if (widx_q == LAST_IDX) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (!debug_mode_i) begin
            if (upd_valid_i) begin
              wr_en    = 1'b1;
              wr_idx   = upd_idx;
              wr_valid = 1'b1;
              wr_ctr   = upd_ctr_new;
            end
            // A mispredict rebuilds history from the branch's snapshot; any
            // speculative push in the same cycle belongs to the wrong path.
            if (upd_valid_i && upd_mispred_i) begin
              ghr_d = shift_in(upd_ghr_i, upd_taken_i);
            end else if (spec_valid_i) begin
              ghr_d = shift_in(ghr_q, spec_taken_i);
            end
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      widx_q  <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ghr_q   <= ghr_d;
    end
  end

  // Table storage has no reset: the init walk defines every entry.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pht_valid[wr_idx] <= wr_valid;
      pht_ctr[wr_idx]   <= wr_ctr;
    end
  end

endmodule

// File: tb/tb_gshare_bht.sv
// tb/tb_gshare_bht.sv - self-checking bench for gshare_bht
module tb_gshare_bht;

  localparam int NR  = 16;
  localparam int HL  = 4;
  localparam int IPF = 2;
  localparam int OFF = 1;
  localparam int VL  = 39;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          debug_mode;
  logic [VL-1:0] vpc;
  logic [IPF-1:0] pred_valid;
  logic [IPF-1:0] pred_taken;
  logic [HL-1:0] ghr;
  logic          spec_valid;
  logic          spec_taken;
  logic          upd_valid;
  logic [VL-1:0] upd_pc;
  logic [HL-1:0] upd_ghr;
  logic          upd_taken;
  logic          upd_mispred;
  logic          init_busy;

  always #5 clk = ~clk;

  gshare_bht #(
    .NR_ENTRIES(NR), .HIST_LEN(HL), .INSTR_PER_FETCH(IPF),
    .OFFSET(OFF), .VLEN(VL), .CTR_INIT(2'b01)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_mode_i(debug_mode),
    .vpc_i(vpc), .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
    .ghr_o(ghr), .spec_valid_i(spec_valid), .spec_taken_i(spec_taken),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr),
    .upd_taken_i(upd_taken), .upd_mispred_i(upd_mispred), .init_busy_o(init_busy)
  );

  typedef struct {
    bit            flush;
    bit            debug;
    logic [VL-1:0] vpc;
    bit            sv;
    bit            st;
    bit            uv;
    logic [VL-1:0] upc;
    logic [HL-1:0] ughr;
    bit            ut;
    bit            um;
    logic [1:0]    e_valid;
    logic [1:0]    e_taken;
    logic [3:0]    e_ghr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: counters as plain integers, history as an integer,
  // init walk as a count of remaining cycles.
  int m_ctr [NR];
  bit m_val [NR];
  int m_ghr;
  int m_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_idx(input logic [VL-1:0] pc, input int h);
    return ((int'(pc >> 1)) % NR) ^ h;
  endfunction

  function automatic vec_t mk(input bit f, input bit d, input logic [VL-1:0] pc,
                              input bit sv, input bit st, input bit uv,
                              input logic [VL-1:0] upc, input logic [HL-1:0] ug,
                              input bit ut, input bit um, input logic [1:0] ev,
                              input logic [1:0] et, input logic [3:0] eg);
    vec_t v;
    v.flush = f; v.debug = d; v.vpc = pc; v.sv = sv; v.st = st; v.uv = uv;
    v.upc = upc; v.ughr = ug; v.ut = ut; v.um = um;
    v.e_valid = ev; v.e_taken = et; v.e_ghr = eg;
    return v;
  endfunction

  function automatic vec_t idle_vec(input logic [VL-1:0] pc);
    return mk(0, 0, pc, 0, 0, 0, '0, '0, 0, 0, 2'b00, 2'b00, 4'h0);
  endfunction

  task automatic model_step(input vec_t v);
    int e;
    if (v.flush) begin
      m_left = NR;
      m_ghr  = 0;
    end else if (m_left > 0) begin
      e = NR - m_left;
      m_ctr[e] = 1;
      m_val[e] = 0;
      m_left--;
    end else if (!v.debug) begin
      if (v.uv) begin
        e = m_idx(v.upc, int'(v.ughr));
        m_val[e] = 1;
        if (v.ut) m_ctr[e] = (m_ctr[e] == 3) ? 3 : m_ctr[e] + 1;
        else      m_ctr[e] = (m_ctr[e] == 0) ? 0 : m_ctr[e] - 1;
      end
      if (v.uv && v.um) m_ghr = ((int'(v.ughr) << 1) | int'(v.ut)) % NR;
      else if (v.sv)    m_ghr = ((m_ghr << 1) | int'(v.st)) % NR;
    end
  endtask

  // Entered and left at a falling edge: drive, sample, clock, update model.
  task automatic cycle(input vec_t v, input bit use_tbl, input string tag, output bit busy_seen);
    logic [1:0] ev, et;
    logic [VL-1:0] spc;
    int e;
    flush = v.flush; debug_mode = v.debug; vpc = v.vpc;
    spec_valid = v.sv; spec_taken = v.st;
    upd_valid = v.uv; upd_pc = v.upc; upd_ghr = v.ughr;
    upd_taken = v.ut; upd_mispred = v.um;
    #1;
    busy_seen = init_busy;
    ev = '0; et = '0;
    for (int s = 0; s < IPF; s++) begin
      spc = v.vpc;
      spc[1] = s[0];
      spc[0] = 1'b0;
      e = m_idx(spc, m_ghr);
      ev[s] = (m_left == 0) && m_val[e];
      et[s] = m_ctr[e] >= 2;
    end
    check({tag, ".busy"}, init_busy, m_left > 0);
    check({tag, ".ghr"}, ghr, m_ghr);
    check({tag, ".valid"}, pred_valid, ev);
    if (m_left == 0) check({tag, ".taken"}, pred_taken, et);
    if (use_tbl) begin
      check({tag, ".tbl_valid"}, pred_valid, v.e_valid);
      check({tag, ".tbl_taken"}, pred_taken, v.e_taken);
      check({tag, ".tbl_ghr"}, ghr, v.e_ghr);
    end
    @(posedge clk);
    model_step(v);
    @(negedge clk);
  endtask

  task automatic count_busy(input int flush_at, input string tag, output int n);
    bit b;
    vec_t v;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      v = idle_vec(VL'($urandom));
      v.flush = (n == flush_at);
      cycle(v, 0, tag, b);
      if (!b) break;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [23];
    vec_t v;
    bit   b;
    int   n;

    rst_n = 1'b0; flush = 0; debug_mode = 0; vpc = '0;
    spec_valid = 0; spec_taken = 0; upd_valid = 0; upd_pc = '0;
    upd_ghr = '0; upd_taken = 0; upd_mispred = 0;
    m_left = NR; m_ghr = 0;
    for (int i = 0; i < NR; i++) begin m_ctr[i] = 1; m_val[i] = 0; end

    //        fl db vpc   sv st uv upc    ughr  ut um  valid  taken  ghr
    tbl[0]  = mk(0, 0, 39'h8, 0, 0, 1, 39'h8,  4'h0, 1, 0, 2'b00, 2'b00, 4'h0);
    tbl[1]  = mk(0, 0, 39'h8, 0, 0, 1, 39'h8,  4'h0, 1, 0, 2'b01, 2'b01, 4'h0);
    tbl[2]  = mk(0, 0, 39'h8, 0, 0, 1, 39'h8,  4'h0, 1, 0, 2'b01, 2'b01, 4'h0);
    tbl[3]  = mk(0, 0, 39'h8, 0, 0, 1, 39'h8,  4'h0, 0, 0, 2'b01, 2'b01, 4'h0);
    tbl[4]  = mk(0, 0, 39'h8, 0, 0, 1, 39'h8,  4'h0, 0, 0, 2'b01, 2'b01, 4'h0);
    tbl[5]  = mk(0, 0, 39'h8, 0, 0, 1, 39'h8,  4'h0, 0, 0, 2'b01, 2'b00, 4'h0);
    tbl[6]  = mk(0, 0, 39'h8, 0, 0, 1, 39'h8,  4'h0, 0, 0, 2'b01, 2'b00, 4'h0);
    tbl[7]  = mk(0, 0, 39'h8, 0, 0, 1, 39'h8,  4'h0, 1, 0, 2'b01, 2'b00, 4'h0);
    tbl[8]  = mk(0, 0, 39'h8, 0, 0, 0, 39'h0,  4'h0, 0, 0, 2'b01, 2'b00, 4'h0);
    tbl[9]  = mk(0, 0, 39'h0, 1, 1, 0, 39'h0,  4'h0, 0, 0, 2'b00, 2'b00, 4'h0);
    tbl[10] = mk(0, 0, 39'h0, 1, 1, 0, 39'h0,  4'h0, 0, 0, 2'b00, 2'b00, 4'h1);
    tbl[11] = mk(0, 0, 39'h0, 1, 0, 0, 39'h0,  4'h0, 0, 0, 2'b00, 2'b00, 4'h3);
    tbl[12] = mk(0, 0, 39'h0, 1, 1, 0, 39'h0,  4'h0, 0, 0, 2'b00, 2'b00, 4'h6);
    tbl[13] = mk(0, 0, 39'h0, 1, 1, 1, 39'h0,  4'h3, 0, 1, 2'b00, 2'b00, 4'hD);
    tbl[14] = mk(0, 0, 39'h0, 0, 0, 0, 39'h0,  4'h0, 0, 0, 2'b00, 2'b00, 4'h6);
    tbl[15] = mk(0, 0, 39'h0, 0, 0, 1, 39'h1E, 4'h2, 1, 1, 2'b00, 2'b00, 4'h6);
    tbl[16] = mk(0, 0, 39'h4, 0, 0, 1, 39'h4,  4'h5, 1, 0, 2'b00, 2'b00, 4'h5);
    tbl[17] = mk(0, 0, 39'h4, 0, 0, 1, 39'h4,  4'h5, 1, 0, 2'b01, 2'b01, 4'h5);
    tbl[18] = mk(0, 0, 39'h4, 0, 0, 1, 39'h1E, 4'h0, 0, 1, 2'b01, 2'b01, 4'h5);
    tbl[19] = mk(0, 0, 39'h4, 0, 0, 0, 39'h0,  4'h0, 0, 0, 2'b10, 2'b00, 4'h0);
    tbl[20] = mk(0, 1, 39'h4, 1, 1, 1, 39'h4,  4'h0, 1, 0, 2'b10, 2'b00, 4'h0);
    tbl[21] = mk(0, 1, 39'h4, 1, 1, 1, 39'h4,  4'h7, 1, 1, 2'b10, 2'b00, 4'h0);
    tbl[22] = mk(0, 0, 39'h4, 0, 0, 0, 39'h0,  4'h0, 0, 0, 2'b10, 2'b00, 4'h0);

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst.busy", init_busy, 1'b1);
    check("rst.valid", pred_valid, 2'b00);
    check("rst.ghr", ghr, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    count_busy(-1, "init", n);
    check("init_len", n, NR);

    for (int r = 0; r < 23; r++) begin
      cycle(tbl[r], 1, $sformatf("row%0d", r), b);
    end

    // Randomized traffic against the model, with occasional flush and debug.
    for (int k = 0; k < 600; k++) begin
      v = idle_vec({7'($urandom), 32'($urandom)});
      v.flush = ($urandom_range(0, 79) == 0);
      v.debug = ($urandom_range(0, 7) == 0);
      v.sv    = $urandom_range(0, 1) == 1;
      v.st    = $urandom_range(0, 1) == 1;
      v.uv    = $urandom_range(0, 2) != 0;
      v.upc   = {7'($urandom), 32'($urandom)};
      v.ughr  = HL'($urandom);
      v.ut    = $urandom_range(0, 3) != 0;
      v.um    = $urandom_range(0, 3) == 0;
      cycle(v, 0, "rand", b);
    end

    // Make sure the walk is done so the next flush lands in IDLE.
    for (int k = 0; k < 40 && m_left > 0; k++) cycle(idle_vec('0), 0, "settle", b);
    check("settled", init_busy, 1'b0);

    // Flush from IDLE with trained entries, then sweep every entry.
    v = idle_vec('0);
    v.flush = 1;
    cycle(v, 0, "flush_idle", b);
    count_busy(-1, "reinit", n);
    check("flush_init_len", n, NR);
    for (int s = 0; s < NR / IPF; s++) begin
      cycle(idle_vec(VL'(s * 4)), 0, "sweep", b);
      check("sweep_invalid", pred_valid, 2'b00);
    end

    // Flush on the 8th walk cycle restarts the walk.
    v = idle_vec('0);
    v.flush = 1;
    cycle(v, 0, "flush_idle2", b);
    count_busy(7, "walk_restart", n);
    check("flush_mid_init_len", n, 8 + NR);

    // Build up some history, then assert reset asynchronously between edges.
    for (int k = 0; k < 4; k++) begin
      v = idle_vec('0);
      v.sv = 1;
      v.st = 1;
      cycle(v, 0, "pre_rst", b);
    end
    check("pre_rst_ghr", ghr, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.busy", init_busy, 1'b1);
    check("async_rst.ghr", ghr, 4'h0);
    check("async_rst.valid", pred_valid, 2'b00);
    m_left = NR;
    m_ghr  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(-1, "init2", n);
    check("init2_len", n, NR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
